// File: rtl/dmem_access_sequencer_if.sv
// Bus bundle between the data-memory sequencer, its two requesters (cpu, dma)
// and the byte-wide memory macro. The sequencer uses the slave view.
interface dmem_access_sequencer_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;
  logic              dma_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done, dma_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done, dma_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_sequencer.sv
// Shares a byte-wide data memory between the cpu and dma ports, splitting each
// doubleword access into little-endian byte beats with cpu-priority arbitration.
module dmem_access_sequencer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dmem_access_sequencer_if.slave  bus,
  output logic                    busy
);
  localparam int NBEATS = DATA_W / 8;
  localparam int BEAT_W = $clog2(NBEATS);
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, XFER, RLAST, DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_dma_q, owner_dma_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-9:0]   rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [BEAT_W-1:0]   prev_beat;
  logic                grant_dma, grant_cpu;

  always_comb begin
    state_d     = state_q;
    owner_dma_d = owner_dma_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    rd_buf_d    = rd_buf_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    prev_beat   = beat_q - BEAT_W'(1);
    grant_dma   = (state_q == IDLE) && bus.dma_req &&
                  (!bus.cpu_req || (starve_q == CNT_W'(STARVE_MAX)));
    grant_cpu   = (state_q == IDLE) && bus.cpu_req && !grant_dma;

    case (state_q)
      IDLE: begin
        if (grant_dma || grant_cpu) begin
          owner_dma_d = grant_dma;
          we_d        = grant_dma ? bus.dma_we    : bus.cpu_we;
          addr_d      = grant_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d     = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          beat_d      = '0;
          err_d       = (addr_d[BEAT_W-1:0] != '0);
          state_d     = err_d ? DONE : XFER;
        end
      end
      XFER: begin
        // Memory read latency is one cycle, so beat b sees the byte of beat b-1.
        if (!we_q && (beat_q != '0)) begin
          rd_buf_d[{prev_beat, 3'b000} +: 8] = bus.mem_rdata;
        end
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          state_d = we_q ? DONE : RLAST;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      RLAST: begin
        if (owner_dma_q) dma_rdata_d = {bus.mem_rdata, rd_buf_q};
        else             cpu_rdata_d = {bus.mem_rdata, rd_buf_q};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation guard: counts cpu wins while dma is kept waiting.
  always_comb begin
    if (!bus.dma_req || grant_dma) begin
      starve_d = '0;
    end else if (grant_cpu && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_dma_q <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat_q      <= '0;
      rd_buf_q    <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_dma_q <= owner_dma_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      rd_buf_q    <= rd_buf_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.mem_en    = (state_q == XFER);
  assign bus.mem_we    = bus.mem_en && we_q;
  assign bus.mem_addr  = bus.mem_en ? (addr_q + ADDR_W'(beat_q)) : '0;
  assign bus.mem_wdata = bus.mem_en ? wdata_q[{beat_q, 3'b000} +: 8] : '0;

  assign bus.cpu_done  = (state_q == DONE) && !owner_dma_q;
  assign bus.dma_done  = (state_q == DONE) && owner_dma_q;
  assign bus.cpu_err   = bus.cpu_done && err_q;
  assign bus.dma_err   = bus.dma_done && err_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_done;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Self-checking bench: directed vector table, arbitration and reset sequences,
// then randomized accesses checked against a doubleword-level memory model.
module tb_dmem_access_sequencer;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;
  localparam logic [63:0] D1 = 64'h8877665544332211;
  localparam logic [63:0] D2 = 64'hF0E1D2C3B4A59687;
  localparam logic [63:0] D3 = 64'h0123456789ABCDEF;
  localparam logic [63:0] DX = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] DY = 64'h5A5A0F0FA5A5F0F0;
  localparam logic [12:0] RBASE = 13'h0800;

  logic clk;
  logic rst_n;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]  tb_mem [0:8191];
  logic [7:0]  mem_rd_r;
  logic [63:0] ref_word [0:15];

  typedef struct {
    bit          dma;
    bit          we;
    logic [12:0] addr;
    logic [63:0] wdata;
    int          lat;
    bit          err;
    logic [63:0] rdata;
    int          en;
  } vec_t;
  vec_t tbl [8];

  dmem_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_access_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rd_r <= tb_mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rd_r;

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = tb_mem[a + i];
    return w;
  endfunction

  task automatic check_access(input string name, input bit dma, input bit we,
                              input logic [12:0] addr, input logic [63:0] wdata,
                              input int exp_lat, input bit exp_err,
                              input logic [63:0] exp_rd, input int exp_en);
    int          lat;
    int          en;
    bit          seen;
    bit          stall_ok;
    logic        err;
    logic [63:0] rd;
    logic [63:0] other;
    other = dma ? bus.cpu_rdata : bus.dma_rdata;
    if (dma) begin
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    lat = 0; en = 0; seen = 1'b0; stall_ok = 1'b1; err = 1'b0; rd = '0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_en) en++;
      if (dma ? bus.dma_done : bus.cpu_done) begin
        seen = 1'b1;
        rd   = dma ? bus.dma_rdata : bus.cpu_rdata;
        err  = dma ? bus.dma_err : bus.cpu_err;
        if (!dma && bus.cpu_stall) stall_ok = 1'b0;
      end else if (!dma && !bus.cpu_stall) begin
        stall_ok = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    chk({name, " done seen"}, seen, 1'b1);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " err"}, err, exp_err);
    chk({name, " mem_en cycles"}, en, exp_en);
    chk({name, " other rdata hold"}, dma ? bus.cpu_rdata : bus.dma_rdata, other);
    if (!we && !exp_err) chk({name, " rdata"}, rd, exp_rd);
    if (!dma) chk({name, " cpu_stall"}, stall_ok, 1'b1);
    $display("xact %s port=%s we=%0d addr=%h lat=%0d err=%0d rdata=%h",
             name, dma ? "dma" : "cpu", we, addr, lat, err, rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          cyc;
    int          waited;
    bit          exp_dma;
    bit          no_done;
    int          w;
    bit          mis;
    logic [12:0] a;
    logic [63:0] d;
    bit          rdma;
    bit          rwe;

    tbl[0] = '{1'b0, 1'b1, 13'h0010, D1, 9,  1'b0, 64'h0, 8};
    tbl[1] = '{1'b0, 1'b0, 13'h0010, 64'h0, 10, 1'b0, D1, 8};
    tbl[2] = '{1'b1, 1'b0, 13'h0013, 64'h0, 1,  1'b1, 64'h0, 0};
    tbl[3] = '{1'b0, 1'b1, 13'h1FF8, D2, 9,  1'b0, 64'h0, 8};
    tbl[4] = '{1'b0, 1'b0, 13'h1FF8, 64'h0, 10, 1'b0, D2, 8};
    tbl[5] = '{1'b1, 1'b1, 13'h0100, D3, 9,  1'b0, 64'h0, 8};
    tbl[6] = '{1'b1, 1'b0, 13'h0100, 64'h0, 10, 1'b0, D3, 8};
    tbl[7] = '{1'b0, 1'b1, 13'h0005, DX, 1,  1'b1, 64'h0, 0};

    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_en", bus.mem_en, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset cpu_done", bus.cpu_done, 1'b0);
    chk("reset dma_done", bus.dma_done, 1'b0);
    chk("reset cpu_rdata", bus.cpu_rdata, 64'h0);
    chk("reset dma_rdata", bus.dma_rdata, 64'h0);
    chk("reset mem_addr", bus.mem_addr, 13'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      check_access($sformatf("vec%0d", i), tbl[i].dma, tbl[i].we, tbl[i].addr,
                   tbl[i].wdata, tbl[i].lat, tbl[i].err, tbl[i].rdata, tbl[i].en);
      if (i == 0) chk("vec0 bytes at 0x010", mem_word(13'h0010), D1);
      if (i == 3) chk("vec3 bytes at 0x1FF8", mem_word(13'h1FF8), D2);
    end
    chk("no wrap into 0x0000", tb_mem[0] === 8'h00 || tb_mem[0] === 8'hxx ? 1'b1 : 1'b0, 1'b1);

    // Both ports requesting continuously: cpu wins until dma has waited STARVE_MAX times.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0010;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 13'h0100;
    n = 0; cyc = 0; waited = 0;
    while (n < 10 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.cpu_done || bus.dma_done) begin
        exp_dma = (waited == STARVE_MAX);
        waited  = exp_dma ? 0 : waited + 1;
        chk($sformatf("arb %0d owner is dma", n), bus.dma_done, exp_dma);
        if (bus.cpu_done) begin
          chk($sformatf("arb %0d cpu_rdata", n), bus.cpu_rdata, D1);
          chk($sformatf("arb %0d dma_rdata hold", n), bus.dma_rdata, D3);
        end else begin
          chk($sformatf("arb %0d dma_rdata", n), bus.dma_rdata, D3);
        end
        $display("xact arb%0d port=%s", n, bus.dma_done ? "dma" : "cpu");
        n++;
        if (n == 10) begin
          bus.cpu_req = 1'b0;
          bus.dma_req = 1'b0;
        end
      end
    end
    chk("arb completions", n, 10);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a store, at beat 3.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0040; bus.cpu_wdata = DX;
    cyc = 0;
    while (!(bus.mem_en && bus.mem_addr == 13'h0043) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst-mid reached beat 3", (cyc < 20), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst-mid mem_en low", bus.mem_en, 1'b0);
    chk("rst-mid busy low", busy, 1'b0);
    bus.cpu_req = 1'b0;
    no_done = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.cpu_done || bus.dma_done) no_done = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (bus.cpu_done || bus.dma_done) no_done = 1'b0;
    chk("rst-mid no done", no_done, 1'b1);
    $display("xact rst-mid aborted store addr=0040");
    check_access("reissue store", 1'b0, 1'b1, 13'h0040, DY, 9, 1'b0, 64'h0, 8);
    check_access("reissue load", 1'b0, 1'b0, 13'h0040, 64'h0, 10, 1'b0, DY, 8);

    // Randomized accesses against a doubleword reference model of a 16-word region.
    for (int i = 0; i < 48; i++) begin
      rdma = 1'($urandom_range(0, 1));
      if (i < 16) begin
        w = i; rwe = 1'b1; mis = 1'b0;
      end else begin
        w   = int'($urandom_range(0, 15));
        rwe = 1'($urandom_range(0, 1));
        mis = ($urandom_range(0, 7) == 0);
      end
      a = RBASE + 13'(w * 8) + (mis ? 13'($urandom_range(1, 7)) : 13'h0);
      d = {$urandom, $urandom};
      if (mis) begin
        check_access($sformatf("rnd%0d", i), rdma, rwe, a, d, 1, 1'b1, 64'h0, 0);
      end else if (rwe) begin
        check_access($sformatf("rnd%0d", i), rdma, 1'b1, a, d, 9, 1'b0, 64'h0, 8);
        ref_word[w] = d;
      end else begin
        check_access($sformatf("rnd%0d", i), rdma, 1'b0, a, d, 10, 1'b0, ref_word[w], 8);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
